inst_encode_loader: RTL and testbench

- Inverse of the instruction decoder: packs opcode/register/immediate fields into 26-bit instruction words.
- Writes those words sequentially into instruction memory at PC-style byte addresses, stepping by 4.
- Used at bring-up and by the test harness to load programs that the pc/Rom/decoder path then fetches.
- Valid/ready field input, handshaked memory write port, per-load instruction count, sticky error flags.

---
 rtl/inst_pkg.sv | 24 ++
 rtl/inst_encode_loader_if.sv | 29 ++
 rtl/inst_pack.sv | 42 ++++
 rtl/inst_encode_loader.sv | 121 ++++++++++++
 tb/tb_inst_encode_loader.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_pkg.sv
// Shared instruction-format definitions for the encode loader and the decoder.
// Field positions are MSB indices of each field within the 26-bit word.
package inst_pkg;
    localparam int INST_W  = 26;
    localparam int OPC_MSB = 25;
    localparam int RD_MSB  = 19;
    localparam int RN_MSB  = 14;
    localparam int RM_MSB  = 9;
    localparam int IMM_W   = 20;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I10 = 2'd1,
        FMT_I15 = 2'd2,
        FMT_I20 = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;
endpackage

// File: rtl/inst_encode_loader_if.sv
// Field-bundle input handshake plus instruction-memory write port of the loader.
interface inst_encode_loader_if #(
    parameter int ADDR_W = 16
);
    import inst_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    fmt_e                 fmt;
    logic [5:0]           opcode;
    logic [4:0]           rd;
    logic [4:0]           rn;
    logic [4:0]           rm;
    logic [IMM_W-1:0]     imm;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [INST_W-1:0]    mem_wdata;
    logic                 mem_ack;

    modport slave (
        input  in_valid, fmt, opcode, rd, rn, rm, imm, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, fmt, opcode, rd, rn, rm, imm, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_pack.sv
// Combinational packer: instruction fields + format -> 26-bit word, with an
// overflow flag when the immediate does not fit its field (value is truncated).
module inst_pack
    import inst_pkg::*;
(
    input  fmt_e              fmt_i,
    input  logic [5:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rn_i,
    input  logic [4:0]        rm_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic [INST_W-1:0] word_o,
    output logic              imm_ovf_o
);
    always_comb begin
        word_o                 = '0;
        imm_ovf_o              = 1'b0;
        word_o[OPC_MSB -: 6]   = opcode_i;
        case (fmt_i)
            FMT_R: begin
                word_o[RD_MSB -: 5] = rd_i;
                word_o[RN_MSB -: 5] = rn_i;
                word_o[RM_MSB -: 5] = rm_i;
            end
            FMT_I10: begin
                word_o[RD_MSB -: 5]  = rd_i;
                word_o[RN_MSB -: 5]  = rn_i;
                word_o[RM_MSB:0]     = imm_i[9:0];
                imm_ovf_o            = |imm_i[19:10];
            end
            FMT_I15: begin
                word_o[RD_MSB -: 5]  = rd_i;
                word_o[RN_MSB:0]     = imm_i[14:0];
                imm_ovf_o            = |imm_i[19:15];
            end
            FMT_I20: begin
                word_o[RD_MSB:0]     = imm_i;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/inst_encode_loader.sv
// Program loader: accepts field bundles, encodes them and writes the words to
// instruction memory at consecutive PC addresses, with count and sticky errors.
module inst_encode_loader
    import inst_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = 8,
    parameter int ADDR_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     num_inst,
    inst_encode_loader_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err_imm,
    output logic                 err_wrap,
    output logic [CNT_W-1:0]     written
);
    // Last address from which another step would wrap past the top of memory.
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}} - ADDR_W'(ADDR_STEP - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    remain_q, remain_d;
    logic [CNT_W-1:0]    written_q, written_d;
    logic [INST_W-1:0]   word_q, word_d;
    logic                err_imm_q, err_imm_d;
    logic                err_wrap_q, err_wrap_d;
    logic [INST_W-1:0]   pack_word;
    logic                pack_ovf;

    inst_pack u_pack (
        .fmt_i     (bus.fmt),
        .opcode_i  (bus.opcode),
        .rd_i      (bus.rd),
        .rn_i      (bus.rn),
        .rm_i      (bus.rm),
        .imm_i     (bus.imm),
        .word_o    (pack_word),
        .imm_ovf_o (pack_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            written_q  <= '0;
            word_q     <= '0;
            err_imm_q  <= 1'b0;
            err_wrap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            written_q  <= written_d;
            word_q     <= word_d;
            err_imm_q  <= err_imm_d;
            err_wrap_q <= err_wrap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        written_d  = written_q;
        word_d     = word_q;
        err_imm_d  = err_imm_q;
        err_wrap_d = err_wrap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = base_addr;
                    remain_d   = num_inst;
                    written_d  = '0;
                    err_imm_d  = 1'b0;
                    err_wrap_d = 1'b0;
                    state_d    = (num_inst == '0) ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (bus.in_valid) begin
                    word_d  = pack_word;
                    state_d = ST_WRITE;
                    if (pack_ovf) err_imm_d = 1'b1;
                end
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    written_d = written_q + CNT_W'(1);
                    remain_d  = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (addr_q == ADDR_LAST) begin
                        err_wrap_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(ADDR_STEP);
                        state_d = ST_ACCEPT;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_ACCEPT);
    assign bus.mem_we    = (state_q == ST_WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = word_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign err_imm       = err_imm_q;
    assign err_wrap      = err_wrap_q;
    assign written       = written_q;
endmodule

// File: tb/tb_inst_encode_loader.sv
// Scoreboard bench for inst_encode_loader: directed loads, a memory responder
// that checks each write against queued expectations, and end-of-load checks.
module tb_inst_encode_loader;
    import inst_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [7:0]  num_inst = '0;
    logic        busy, done, err_imm, err_wrap;
    logic [7:0]  written;

    typedef struct {
        logic [15:0] addr;
        logic [25:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ack_delay = 0;
    int   wait_cnt = 0;

    inst_encode_loader_if #(.ADDR_W(16)) bus ();

    inst_encode_loader #(.ADDR_W(16), .CNT_W(8), .ADDR_STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_inst  (num_inst),
        .bus       (bus.slave),
        .busy      (busy),
        .done      (done),
        .err_imm   (err_imm),
        .err_wrap  (err_wrap),
        .written   (written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder and scoreboard monitor.
    initial begin
        exp_t e;
        bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst && bus.mem_we) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: write at 0x%0h data 0x%0h with no expected entry",
                             bus.mem_addr, bus.mem_wdata);
                    bus.mem_ack = 1'b1;
                end else if (wait_cnt >= ack_delay) begin
                    e = sb_q.pop_front();
                    chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                    chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.word));
                    bus.mem_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    chk("hold_addr", 32'(bus.mem_addr), 32'(sb_q[0].addr));
                    chk("hold_wdata", 32'(bus.mem_wdata), 32'(sb_q[0].word));
                    chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
                    bus.mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic do_start(input logic [15:0] b, input logic [7:0] n);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        num_inst = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input fmt_e f, input logic [5:0] op, input logic [4:0] d,
                        input logic [4:0] n, input logic [4:0] m, input logic [19:0] im,
                        input logic [15:0] exp_addr, input logic [25:0] exp_word);
        exp_t e;
        e.addr = exp_addr;
        e.word = exp_word;
        sb_q.push_back(e);
        bus.fmt = f;
        bus.opcode = op;
        bus.rd = d;
        bus.rn = n;
        bus.rm = m;
        bus.imm = im;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) break;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk("we_latency", 32'(bus.mem_we), 32'd1);
        end
    endtask

    task automatic wait_done(input logic [7:0] exp_w, input logic exp_imm, input logic exp_wrap);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("written", 32'(written), 32'(exp_w));
        chk("err_imm", 32'(err_imm), 32'(exp_imm));
        chk("err_wrap", 32'(err_wrap), 32'(exp_wrap));
        chk("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.fmt = FMT_R;
        bus.opcode = '0;
        bus.rd = '0;
        bus.rn = '0;
        bus.rm = '0;
        bus.imm = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_flags", {28'd0, busy, done, err_imm, err_wrap}, 32'd0);
        chk("rst_written", 32'(written), 32'd0);
        rst = 1'b1;

        // Single R-format word, immediate ack
        do_start(16'h0000, 8'd1);
        send(FMT_R, 6'h01, 5'd3, 5'd1, 5'd2, 20'h0, 16'h0000, 26'h0118440);
        wait_done(8'd1, 1'b0, 1'b0);

        // Three mixed formats at 0x10
        do_start(16'h0010, 8'd3);
        send(FMT_I20, 6'h3F, 5'd0, 5'd0, 5'd0, 20'hABCDE, 16'h0010, 26'h3FABCDE);
        send(FMT_I10, 6'h02, 5'd4, 5'd5, 5'd0, 20'h003FF, 16'h0014, 26'h02217FF);
        send(FMT_R,   6'h01, 5'd3, 5'd1, 5'd2, 20'h0,     16'h0018, 26'h0118440);
        wait_done(8'd3, 1'b0, 1'b0);

        // I10 immediate overflow: truncated, sticky error
        do_start(16'h0040, 8'd2);
        send(FMT_I10, 6'h02, 5'd4, 5'd5, 5'd0, 20'h00401, 16'h0040, 26'h0221401);
        send(FMT_I15, 6'h05, 5'd1, 5'd0, 5'd0, 20'h07FFF, 16'h0044, 26'h050FFFF);
        wait_done(8'd2, 1'b1, 1'b0);

        // Delayed ack, stray start while busy; next start clears err_imm
        ack_delay = 3;
        do_start(16'h0080, 8'd1);
        chk("err_imm_cleared", 32'(err_imm), 32'd0);
        send(FMT_I15, 6'h0A, 5'd7, 5'd0, 5'd0, 20'h08000, 16'h0080, 26'h0A38000);
        @(negedge clk);
        start = 1'b1;
        base_addr = 16'h0500;
        num_inst = 8'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(8'd1, 1'b1, 1'b0);
        ack_delay = 0;

        // Address wrap abort
        do_start(16'hFFF8, 8'd4);
        send(FMT_R, 6'h01, 5'd3, 5'd1, 5'd2, 20'h0, 16'hFFF8, 26'h0118440);
        send(FMT_I20, 6'h3F, 5'd0, 5'd0, 5'd0, 20'hABCDE, 16'hFFFC, 26'h3FABCDE);
        wait_done(8'd2, 1'b0, 1'b1);

        // Zero-length load
        do_start(16'h0100, 8'd0);
        wait_done(8'd0, 1'b0, 1'b0);

        // Reset during WRITE, then a clean load from a new base
        ack_delay = 20;
        do_start(16'h0100, 8'd1);
        send(FMT_R, 6'h01, 5'd3, 5'd1, 5'd2, 20'h0, 16'h0100, 26'h0118440);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_addr", 32'(bus.mem_addr), 32'd0);
        sb_q.delete();
        ack_delay = 0;
        @(negedge clk);
        rst = 1'b1;
        do_start(16'h0200, 8'd1);
        send(FMT_R, 6'h01, 5'd3, 5'd1, 5'd2, 20'h0, 16'h0200, 26'h0118440);
        wait_done(8'd1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
